// File: rtl/alu_issue_stage.sv
// Decode/operand stage feeding the ALU: decodes RV32I OP/OP-IMM words, reads the
// register file with forwarding from the execute stage, and writes ALU results back.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_RUN  | accepting instructions, one per cycle
// S_HALT | illegal instruction seen; input ignored until reset
module alu_issue_stage #(
    parameter int RETIRE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [31:0]         i_instr,
    output logic                o_ready,
    output logic [31:0]         o_alu_a,
    output logic [31:0]         o_alu_b,
    output logic [3:0]          o_alu_op,
    input  logic [31:0]         i_alu_res,
    output logic                o_wb_valid,
    output logic [4:0]          o_wb_rd,
    output logic [31:0]         o_wb_data,
    output logic                o_halted,
    output logic [31:0]         o_bad_instr,
    output logic [RETIRE_W-1:0] o_retired,
    input  logic [4:0]          i_dbg_addr,
    output logic [31:0]         o_dbg_data
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           rf_q [32];
    logic                  e_valid_q, e_valid_d;
    logic [4:0]            e_rd_q, e_rd_d;
    logic [31:0]           e_a_q, e_a_d;
    logic [31:0]           e_b_q, e_b_d;
    logic [3:0]            e_op_q, e_op_d;
    logic [31:0]           bad_q, bad_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        dec_legal;
    logic        dec_use_imm;
    logic        dec_shift;
    logic [3:0]  dec_op;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] dec_b;
    logic        ready;
    logic        accept;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];
    assign imm    = {{20{i_instr[31]}}, i_instr[31:20]};

    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_shift   = 1'b0;
        dec_op      = OP_ADD;
        if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
            dec_use_imm = (opcode == OPC_OPIMM);
            dec_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
            case (funct3)
                3'b000: begin
                    // OP-IMM has no SUB form; funct7 bits are immediate there
                    if (dec_use_imm) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ADD;
                    end else begin
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_op    = (funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                    end
                end
                3'b001: begin
                    dec_legal = (funct7 == F7_ZERO);
                    dec_op    = OP_SLL;
                end
                3'b010: begin
                    dec_legal = dec_use_imm || (funct7 == F7_ZERO);
                    dec_op    = OP_SLT;
                end
                3'b011: begin
                    dec_legal = dec_use_imm || (funct7 == F7_ZERO);
                    dec_op    = OP_SLTU;
                end
                3'b100: begin
                    dec_legal = dec_use_imm || (funct7 == F7_ZERO);
                    dec_op    = OP_XOR;
                end
                3'b101: begin
                    dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    dec_op    = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                end
                3'b110: begin
                    dec_legal = dec_use_imm || (funct7 == F7_ZERO);
                    dec_op    = OP_OR;
                end
                default: begin
                    dec_legal = dec_use_imm || (funct7 == F7_ZERO);
                    dec_op    = OP_AND;
                end
            endcase
        end
    end

    // x0 reads zero before forwarding is considered, so an E-stage write to x0 never leaks
    always_comb begin
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        if (rs1 != 5'd0) begin
            rs1_val = (e_valid_q && e_rd_q == rs1) ? i_alu_res : rf_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (e_valid_q && e_rd_q == rs2) ? i_alu_res : rf_q[rs2];
        end
    end

    always_comb begin
        dec_b = dec_use_imm ? imm : rs2_val;
        if (dec_shift) begin
            dec_b = {27'd0, (dec_use_imm ? i_instr[24:20] : rs2_val[4:0])};
        end
    end

    assign ready  = (state_q == S_RUN) && !i_rst;
    assign accept = i_valid && ready;

    always_comb begin
        state_d   = state_q;
        e_valid_d = 1'b0;
        e_rd_d    = e_rd_q;
        e_a_d     = e_a_q;
        e_b_d     = e_b_q;
        e_op_d    = e_op_q;
        bad_d     = bad_q;
        retired_d = e_valid_q ? retired_q + RETIRE_W'(1) : retired_q;
        if (accept) begin
            if (dec_legal) begin
                e_valid_d = 1'b1;
                e_rd_d    = rd;
                e_a_d     = rs1_val;
                e_b_d     = dec_b;
                e_op_d    = dec_op;
            end else begin
                state_d = S_HALT;
                bad_d   = i_instr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_RUN;
            e_valid_q <= 1'b0;
            e_rd_q    <= 5'd0;
            e_a_q     <= 32'd0;
            e_b_q     <= 32'd0;
            e_op_q    <= OP_ADD;
            bad_q     <= 32'd0;
            retired_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            e_valid_q <= e_valid_d;
            e_rd_q    <= e_rd_d;
            e_a_q     <= e_a_d;
            e_b_q     <= e_b_d;
            e_op_q    <= e_op_d;
            bad_q     <= bad_d;
            retired_q <= retired_d;
            if (e_valid_q && e_rd_q != 5'd0) begin
                rf_q[e_rd_q] <= i_alu_res;
            end
        end
    end

    assign o_ready     = ready;
    assign o_alu_a     = e_a_q;
    assign o_alu_b     = e_b_q;
    assign o_alu_op    = e_op_q;
    assign o_wb_valid  = e_valid_q;
    assign o_wb_rd     = e_rd_q;
    assign o_wb_data   = i_alu_res;
    assign o_halted    = (state_q == S_HALT);
    assign o_bad_instr = bad_q;
    assign o_retired   = retired_q;
    assign o_dbg_data  = (i_dbg_addr == 5'd0) ? 32'd0 : rf_q[i_dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: an ALU model closes the loop, a scoreboard checks every
// writeback, and directed checks cover decode, forwarding, halt and reset.
module tb_alu_issue_stage;

    localparam int RW = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic [31:0]   i_instr;
    logic          o_ready;
    logic [31:0]   o_alu_a;
    logic [31:0]   o_alu_b;
    logic [3:0]    o_alu_op;
    logic [31:0]   i_alu_res;
    logic          o_wb_valid;
    logic [4:0]    o_wb_rd;
    logic [31:0]   o_wb_data;
    logic          o_halted;
    logic [31:0]   o_bad_instr;
    logic [RW-1:0] o_retired;
    logic [4:0]    i_dbg_addr;
    logic [31:0]   o_dbg_data;

    alu_issue_stage #(.RETIRE_W(RW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_instr     (i_instr),
        .o_ready     (o_ready),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .i_alu_res   (i_alu_res),
        .o_wb_valid  (o_wb_valid),
        .o_wb_rd     (o_wb_rd),
        .o_wb_data   (o_wb_data),
        .o_halted    (o_halted),
        .o_bad_instr (o_bad_instr),
        .o_retired   (o_retired),
        .i_dbg_addr  (i_dbg_addr),
        .o_dbg_data  (o_dbg_data)
    );

    always #5 i_clk = ~i_clk;

    // Downstream ALU model
    always_comb begin
        i_alu_res = 32'd0;
        case (o_alu_op)
            OP_ADD:  i_alu_res = o_alu_a + o_alu_b;
            OP_SUB:  i_alu_res = o_alu_a - o_alu_b;
            OP_SLL:  i_alu_res = o_alu_a << o_alu_b[4:0];
            OP_SLT:  i_alu_res = {31'd0, $signed(o_alu_a) < $signed(o_alu_b)};
            OP_SLTU: i_alu_res = {31'd0, o_alu_a < o_alu_b};
            OP_XOR:  i_alu_res = o_alu_a ^ o_alu_b;
            OP_SRL:  i_alu_res = o_alu_a >> o_alu_b[4:0];
            OP_SRA:  i_alu_res = $unsigned($signed(o_alu_a) >>> o_alu_b[4:0]);
            OP_OR:   i_alu_res = o_alu_a | o_alu_b;
            OP_AND:  i_alu_res = o_alu_a & o_alu_b;
            default: i_alu_res = 32'd0;
        endcase
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [36:0] exp_q [$];
    logic [36:0] exp_e;

    always @(negedge i_clk) begin
        if (!i_rst && o_wb_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%08h, required no writeback",
                         o_wb_rd, o_wb_data);
            end else begin
                exp_e = exp_q.pop_front();
                if (o_wb_rd !== exp_e[36:32] || o_wb_data !== exp_e[31:0]) begin
                    n_err++;
                    $display("FAIL wb: got rd=%0d data=0x%08h, required rd=%0d data=0x%08h",
                             o_wb_rd, o_wb_data, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] instr, input logic wb,
                         input logic [4:0] rd, input logic [31:0] data);
        i_valid = 1'b1;
        i_instr = instr;
        @(posedge i_clk);
        if (wb) exp_q.push_back({rd, data});
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic dbg(input logic [4:0] addr, input logic [31:0] req, input string name);
        i_dbg_addr = addr;
        #1;
        check32(name, o_dbg_data, req);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_instr    = 32'd0;
        i_dbg_addr = 5'd0;
        repeat (2) @(posedge i_clk);
        #1;
        check32("rst_ready",    {31'd0, o_ready},    32'd0);
        check32("rst_alu_a",    o_alu_a,             32'd0);
        check32("rst_alu_b",    o_alu_b,             32'd0);
        check32("rst_alu_op",   {28'd0, o_alu_op},   {28'd0, OP_ADD});
        check32("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        check32("rst_wb_rd",    {27'd0, o_wb_rd},    32'd0);
        i_rst = 1'b0;
        #1;
        check32("ready_after_rst", {31'd0, o_ready},  32'd1);
        check32("retired_rst",     {16'd0, o_retired}, 32'd0);
        check32("halted_rst",      {31'd0, o_halted}, 32'd0);
        check32("bad_rst",         o_bad_instr,       32'd0);
        for (int r = 0; r < 32; r++) dbg(5'(r), 32'd0, "rf_rst");

        // dependent chain with forwarding into SUB
        issue(32'h00500093, 1'b1, 5'd1, 32'd5);
        issue(32'h00300113, 1'b1, 5'd2, 32'd3);
        issue(32'h402081B3, 1'b1, 5'd3, 32'd2);
        i_valid = 1'b0;
        check32("sub_op", {28'd0, o_alu_op}, {28'd0, OP_SUB});
        check32("sub_a",  o_alu_a, 32'd5);
        check32("sub_b",  o_alu_b, 32'd3);
        idle(2);
        dbg(5'd3, 32'd2, "x3");
        check32("retired_3", {16'd0, o_retired}, 32'd3);

        // shifts by immediate on a negative value
        issue(32'hFF200213, 1'b1, 5'd4, 32'hFFFFFFF2);
        issue(32'h40225293, 1'b1, 5'd5, 32'hFFFFFFFC);
        check32("srai_b",  o_alu_b, 32'd2);
        check32("srai_op", {28'd0, o_alu_op}, {28'd0, OP_SRA});
        issue(32'h00225313, 1'b1, 5'd6, 32'h3FFFFFFC);
        i_valid = 1'b0;
        check32("srli_b",  o_alu_b, 32'd2);
        check32("srli_op", {28'd0, o_alu_op}, {28'd0, OP_SRL});
        idle(2);
        dbg(5'd4, 32'hFFFFFFF2, "x4");
        dbg(5'd5, 32'hFFFFFFFC, "x5");
        dbg(5'd6, 32'h3FFFFFFC, "x6");

        // writes to x0 retire but do not stick or forward
        issue(32'h00700013, 1'b1, 5'd0, 32'd7);
        issue(32'h000003B3, 1'b1, 5'd7, 32'd0);
        idle(2);
        dbg(5'd0, 32'd0, "x0");
        dbg(5'd7, 32'd0, "x7");
        check32("retired_8", {16'd0, o_retired}, 32'd8);

        // signed vs unsigned compare
        issue(32'hFFD00093, 1'b1, 5'd1, 32'hFFFFFFFD);
        issue(32'h00300113, 1'b1, 5'd2, 32'd3);
        issue(32'h0020B433, 1'b1, 5'd8, 32'd0);
        issue(32'h0020A4B3, 1'b1, 5'd9, 32'd1);
        idle(2);
        dbg(5'd8, 32'd0, "x8");
        dbg(5'd9, 32'd1, "x9");
        check32("retired_12", {16'd0, o_retired}, 32'd12);

        // illegal instruction behind a legal one
        issue(32'h00500093, 1'b1, 5'd1, 32'd5);
        issue(32'h0000006F, 1'b0, 5'd0, 32'd0);
        check32("halted",     {31'd0, o_halted}, 32'd1);
        check32("bad_instr",  o_bad_instr,       32'h0000006F);
        check32("halt_ready", {31'd0, o_ready},  32'd0);
        dbg(5'd1, 32'd5, "x1_before_halt");
        for (int k = 0; k < 3; k++) issue(32'h00100513, 1'b0, 5'd0, 32'd0);
        i_valid = 1'b0;
        check32("halt_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        dbg(5'd10, 32'd0, "x10_ignored");
        check32("retired_13", {16'd0, o_retired}, 32'd13);

        i_rst = 1'b1;
        #1;
        check32("rst2_ready", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        check32("rst2_ready_after", {31'd0, o_ready},  32'd1);
        check32("rst2_halted",      {31'd0, o_halted}, 32'd0);
        check32("rst2_bad",         o_bad_instr,       32'd0);
        check32("rst2_retired",     {16'd0, o_retired}, 32'd0);
        dbg(5'd1, 32'd0, "rst2_x1");
        dbg(5'd9, 32'd0, "rst2_x9");

        // reset during an in-flight writeback discards it
        issue(32'h00900593, 1'b0, 5'd0, 32'd0);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        dbg(5'd11, 32'd0, "x11_discarded");
        check32("rst3_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        check32("rst3_retired",  {16'd0, o_retired},  32'd0);
        idle(2);

        check32("scoreboard_left", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand stage that sits directly upstream of the `alu` block.
- Accepts RV32I OP and OP-IMM instruction words over a valid/ready handshake and decodes each into the `alu` opcode enum from `opcode.svh`.
- Reads operands from an internal 32x32 register file and drives `i_a`/`i_b`/`i_op` of the ALU.
- Writes the ALU result back to the register file, with forwarding so back-to-back dependent instructions never stall.

Parameters:
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  i_instr is presented.
- i_instr  input  32  RV32I instruction word.
- o_ready  output  1  stage accepts an instruction this cycle.
- o_alu_a  output  32  to alu.i_a.
- o_alu_b  output  32  to alu.i_b.
- o_alu_op  output  4  to alu.i_op (opcode.svh enum).
- i_alu_res  input  32  from alu.o_res (combinational).
- o_wb_valid  output  1  writeback occurs at the end of this cycle.
- o_wb_rd  output  5  writeback destination register.
- o_wb_data  output  32  writeback value (equals i_alu_res).
- o_halted  output  1  illegal instruction seen; stage stopped.
- o_bad_instr  output  32  the offending instruction word, captured.
- o_retired  output  RETIRE_W  count of writebacks.
- i_dbg_addr  input  5  debug register-file read address.
- o_dbg_data  output  32  combinational register-file read; x0 always reads 0.

Behaviour:
- Two stages:
  - D: decode and register read, on the accept cycle.
  - E: execute and writeback.
- An instruction is accepted when i_valid && o_ready at cycle N.
  - Decoded operands and op are registered into E at the edge ending cycle N.
  - In cycle N+1, o_alu_* come from the E registers, o_wb_valid=1, and o_wb_rd/o_wb_data are valid.
  - The register file is written at the edge ending cycle N+1.
  - Latency from accept to result in the register file is 2 edges; throughput is 1 per cycle.
- Forwarding:
  - When D reads rs1/rs2 equal to E.rd, with E valid and E.rd != 0, D uses i_alu_res instead of the register file.
  - A read of x0 always yields 0, even if E.rd == 0.
- Writes to x0 still raise o_wb_valid with o_wb_rd=0 and count as retired, but do not change x0.
- Decode for opcode 0110011 (OP), funct7 must be 0000000 unless noted:
  - funct3 000: ADD; with funct7 0100000: SUB.
  - funct3 001: SLL.
  - funct3 010: SLT.
  - funct3 011: SLTU.
  - funct3 100: XOR.
  - funct3 101: SRL; with funct7 0100000: SRA.
  - funct3 110: OR.
  - funct3 111: AND.
  - o_alu_b = rs2 value.
- Decode for opcode 0010011 (OP-IMM):
  - imm = sign-extended instr[31:20]; o_alu_b = imm.
  - funct3 000/010/011/100/110/111 map to ADD/SLT/SLTU/XOR/OR/AND.
  - funct3 001: SLLI, requires instr[31:25] = 0.
  - funct3 101: SRLI if instr[31:25] = 0; SRAI if instr[31:25] = 0100000.
- Shift ops (both forms): o_alu_b = {27'b0, shamt[4:0]}, so the ALU always sees shift amounts of 0..31.
- Any other opcode or funct7 is illegal:
  - The instruction is not issued to E.
  - o_bad_instr is captured and o_halted=1 from the next cycle.
  - The instruction already in E still completes its writeback.
- State machine:
  - RUN: o_ready=1.
  - RUN -> HALT on acceptance of an illegal instruction.
  - HALT: o_ready=0; i_valid is ignored; E drains; only i_rst exits HALT.
- While i_valid=0 in RUN, E becomes empty (o_wb_valid=0). o_alu_* then hold their last value; they are don't-care for checking.
- o_retired increments on each o_wb_valid cycle and wraps from all-ones to 0.
- Reset (i_rst high at an edge), including reset mid-operation:
  - All 31 writable registers go to 0; E is emptied and an in-flight writeback is discarded.
  - State goes to RUN; o_halted=0; o_bad_instr=0; o_retired=0.
  - o_alu_a=0, o_alu_b=0, o_alu_op=ADD.
  - o_wb_valid=0, o_wb_rd=0, o_wb_data=don't-care.
  - o_ready=0 while i_rst is high; o_ready=1 the first cycle after.

Test Plan:
1. Reset, then sweep i_dbg_addr 0..31 -> every o_dbg_data=0; o_ready=1; o_retired=0; o_halted=0.
2. Back-to-back 0x00500093 (addi x1,x0,5), 0x00300113 (addi x2,x0,3), 0x402081B3 (sub x3,x1,x2) -> in the SUB's E cycle o_alu_op=SUB, o_alu_a=5, o_alu_b=3 (x2 forwarded); x3=2; o_retired=3.
3. 0xFF200213 (addi x4,x0,-14), 0x40225293 (srai x5,x4,2), 0x00225313 (srli x6,x4,2) -> x4=0xFFFFFFF2, x5=0xFFFFFFFC, x6=0x3FFFFFFC; o_alu_b=2 for both shifts.
4. 0x00700013 (addi x0,x0,7), then 0x000003B3 (add x7,x0,x0) -> o_wb_valid=1 with o_wb_rd=0 on the first; x0 reads 0; x7=0 (no forwarding of x0); o_retired +2.
5. x1=-3 via 0xFFD00093, x2=3, then 0x0020B433 (sltu x8,x1,x2) and 0x0020A4B3 (slt x9,x1,x2) -> x8=0, x9=1.
6. 0x00500093 immediately followed by 0x0000006F (jal) -> x1=5 is still written; o_halted=1 and o_bad_instr=0x0000006F next cycle; o_ready=0; further valid instructions have no effect. Assert i_rst -> RUN, all registers 0, o_ready=1 the cycle after reset.
